// File: rtl/caliptra_prim_blank_ctrl.sv
// rtl/caliptra_prim_blank_ctrl.sv - registered blanking enable controller gating a secret path

// Bitwise AND gate used to blank the secret path.
module caliptra_prim_and2 #(
  parameter int Width = 1
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  output logic [Width-1:0] y
);

  assign y = a & b;

endmodule

// Controller that opens a blanking window after a handshake plus arming delay.
module caliptra_prim_blank_ctrl #(
  parameter int Width         = 32,
  parameter int ArmCycles     = 2,
  parameter int MaxOpenCycles = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             src_valid_i,
  input  logic             lock_i,
  input  logic             ack_i,
  input  logic [Width-1:0] data_i,
  output logic             en_o,
  output logic [Width-1:0] data_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic             locked_o
);

  // The counter serves both the arming delay and the open window.
  localparam int MaxCnt = (ArmCycles > MaxOpenCycles) ? ArmCycles : MaxOpenCycles;
  localparam int CntW   = $clog2(MaxCnt + 1);

  localparam logic [CntW-1:0] ArmLast  = CntW'(ArmCycles - 1);
  localparam logic [CntW-1:0] OpenLast = CntW'(MaxOpenCycles - 1);
  localparam logic [CntW-1:0] CntSat   = {CntW{1'b1}};

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StOpen,
    StClose,
    StLocked
  } state_e;

  state_e          state;
  logic [CntW-1:0] cnt;
  logic [CntW-1:0] cnt_inc;
  logic            drop;
  logic            en_q;
  logic            done_q;
  logic            timeout_q;
  logic            locked_q;

  // Saturating increment so a long hold can never wrap back to a match value.
  assign cnt_inc = (cnt == CntSat) ? cnt : cnt + CntW'(1);

  // Either half of the handshake going away abandons the transfer.
  assign drop = !req_i || !src_valid_i;

  // Controller state, counter and all outputs; enable is set on the edge that enters Open.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= StIdle;
      cnt       <= '0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (lock_i) begin
        // Lock overrides everything, including a same-cycle ack.
        state    <= StLocked;
        cnt      <= '0;
        en_q     <= 1'b0;
        locked_q <= 1'b1;
      end else begin
        case (state)
          StIdle: begin
            if (req_i && src_valid_i) begin
              state <= StArm;
              cnt   <= '0;
            end
          end
          StArm: begin
            if (drop) begin
              state <= StIdle;
              cnt   <= '0;
            end else if (cnt == ArmLast) begin
              state <= StOpen;
              cnt   <= '0;
              en_q  <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
          StOpen: begin
            if (ack_i || drop) begin
              state  <= StClose;
              cnt    <= '0;
              en_q   <= 1'b0;
              done_q <= 1'b1;
            end else if (cnt == OpenLast) begin
              state     <= StClose;
              cnt       <= '0;
              en_q      <= 1'b0;
              done_q    <= 1'b1;
              timeout_q <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
          StClose: begin
            // No re-open until the consumer withdraws its request.
            if (!req_i) begin
              state <= StIdle;
            end
          end
          StLocked: begin
            state <= StLocked;
          end
          default: begin
            state <= StIdle;
            cnt   <= '0;
            en_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign en_o      = en_q;
  assign done_o    = done_q;
  assign timeout_o = timeout_q;
  assign locked_o  = locked_q;

  caliptra_prim_and2 #(
    .Width(Width)
  ) u_blank_and (
    .a(data_i),
    .b({Width{en_q}}),
    .y(data_o)
  );

endmodule

// File: tb/tb_caliptra_prim_blank_ctrl.sv
// tb/tb_caliptra_prim_blank_ctrl.sv - self-checking bench for caliptra_prim_blank_ctrl
module tb_caliptra_prim_blank_ctrl;

  localparam int ARM  = 2;
  localparam int MAXO = 16;

  logic        clk;
  logic        rst;
  logic        req;
  logic        src_valid;
  logic        lock;
  logic        ack;
  logic [31:0] data_in;
  logic        en;
  logic [31:0] data_out;
  logic        done;
  logic        timeout;
  logic        locked;

  int passed;
  int total;
  int failed;

  // Reference model: remaining open budget, arming progress, closing flag, lock and sticky timeout.
  int m_open_left;
  int m_arm_elapsed;
  bit m_closing;
  bit m_locked;
  bit m_done;
  bit m_timeout;
  bit m_en;

  caliptra_prim_blank_ctrl #(
    .Width(32),
    .ArmCycles(ARM),
    .MaxOpenCycles(MAXO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_i(req),
    .src_valid_i(src_valid),
    .lock_i(lock),
    .ack_i(ack),
    .data_i(data_in),
    .en_o(en),
    .data_o(data_out),
    .done_o(done),
    .timeout_o(timeout),
    .locked_o(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_open_left   = 0;
    m_arm_elapsed = -1;
    m_closing     = 1'b0;
    m_locked      = 1'b0;
    m_done        = 1'b0;
    m_timeout     = 1'b0;
    m_en          = 1'b0;
  endtask

  task automatic model_step(input bit r, input bit v, input bit a, input bit l);
    m_done = 1'b0;
    if (m_locked) begin
      m_en = 1'b0;
    end else if (l) begin
      m_locked      = 1'b1;
      m_open_left   = 0;
      m_arm_elapsed = -1;
      m_closing     = 1'b0;
    end else if (m_open_left > 0) begin
      if (a || !r || !v || m_open_left == 1) begin
        if (!a && r && v) m_timeout = 1'b1;
        m_open_left = 0;
        m_closing   = 1'b1;
        m_done      = 1'b1;
      end else begin
        m_open_left = m_open_left - 1;
      end
    end else if (m_closing) begin
      if (!r) m_closing = 1'b0;
    end else if (m_arm_elapsed >= 0) begin
      if (!r || !v) begin
        m_arm_elapsed = -1;
      end else if (m_arm_elapsed + 1 == ARM) begin
        m_arm_elapsed = -1;
        m_open_left   = MAXO;
      end else begin
        m_arm_elapsed = m_arm_elapsed + 1;
      end
    end else if (r && v) begin
      m_arm_elapsed = 0;
    end
    m_en = (m_open_left > 0);
  endtask

  task automatic check_model();
    chk1("m_en", en, m_en);
    chk32("m_data", data_out, m_en ? data_in : 32'h0);
    chk1("m_done", done, m_done);
    chk1("m_timeout", timeout, m_timeout);
    chk1("m_locked", locked, m_locked);
  endtask

  task automatic step(input bit r, input bit v, input bit a, input bit l, input logic [31:0] d);
    req       = r;
    src_valid = v;
    ack       = a;
    lock      = l;
    data_in   = d;
    @(posedge clk);
    model_step(r, v, a, l);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req       = 1'b0;
    src_valid = 1'b0;
    ack       = 1'b0;
    lock      = 1'b0;
    data_in   = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    chk1("rst_en", en, 1'b0);
    chk32("rst_data", data_out, 32'h0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_timeout", timeout, 1'b0);
    chk1("rst_locked", locked, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    int c;
    int dcount;
    bit r;
    bit v;
    bit a;
    bit l;
    passed = 0;
    total  = 0;
    failed = 0;
    model_reset();

    // Acked transfer.
    do_reset();
    for (int n = 0; n < 10; n++) begin
      step(1'b1, 1'b1, n == 5, 1'b0, 32'hA5A5_5A5A);
      c = n + 1;
      chk1("t1_en", en, c >= 3 && c <= 5);
      chk32("t1_data", data_out, (c >= 3 && c <= 5) ? 32'hA5A5_5A5A : 32'h0);
      chk1("t1_done", done, c == 6);
      chk1("t1_timeout", timeout, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'hA5A5_5A5A);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'hA5A5_5A5A);

    // Timeout, then a second acked transfer keeps timeout sticky.
    do_reset();
    for (int n = 0; n < 20; n++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h1234_5678);
      c = n + 1;
      chk1("t2_en", en, c >= 3 && c <= 18);
      chk1("t2_done", done, c == 19);
      chk1("t2_timeout", timeout, c >= 19);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int n = 0; n < 7; n++) step(1'b1, 1'b1, n == 3, 1'b0, 32'hCAFE_F00D);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk1("t2_sticky", timeout, 1'b1);

    // Valid drops during Arm.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
    for (int n = 1; n < 9; n++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
      chk1("t3_en", en, 1'b0);
      chk1("t3_done", done, 1'b0);
    end
    for (int n = 0; n < 5; n++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0F0F_0F0F);
    chk1("t3_rearm_en", en, 1'b1);

    // Lock and ack together in Open.
    do_reset();
    for (int n = 0; n < 4; n++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h5555_AAAA);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h5555_AAAA);
    chk1("t4_en", en, 1'b0);
    chk1("t4_locked", locked, 1'b1);
    chk1("t4_done", done, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h5555_AAAA);
    for (int n = 0; n < 8; n++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h5555_AAAA);
      chk1("t4_ign_en", en, 1'b0);
      chk1("t4_ign_locked", locked, 1'b1);
    end

    // Hold req through Close.
    do_reset();
    for (int n = 0; n < 4; n++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0BAD_F00D);
    dcount = 0;
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0BAD_F00D);
    dcount = dcount + int'(done);
    for (int n = 0; n < 10; n++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0BAD_F00D);
      dcount = dcount + int'(done);
      chk1("t5_en", en, 1'b0);
    end
    chk32("t5_done_cnt", 32'(dcount), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int n = 0; n < 4; n++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h7777_1111);
    chk1("t5_reopen_en", en, 1'b1);

    // Asynchronous reset mid-Open.
    do_reset();
    for (int n = 0; n < 4; n++) step(1'b1, 1'b1, 1'b0, 1'b0, 32'hFACE_B00C);
    chk1("t6_pre_en", en, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk1("t6_async_en", en, 1'b0);
    chk32("t6_async_data", data_out, 32'h0);
    for (int n = 0; n < 2; n++) begin
      @(posedge clk);
      @(negedge clk);
      chk1("t6_hold_en", en, 1'b0);
      chk32("t6_hold_data", data_out, 32'h0);
      chk1("t6_hold_done", done, 1'b0);
      chk1("t6_hold_timeout", timeout, 1'b0);
      chk1("t6_hold_locked", locked, 1'b0);
    end
    rst = 1'b0;
    model_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 900; i++) begin
      if (i % 150 == 0) do_reset();
      if ((i / 75) % 2 == 0) begin
        r = ($urandom_range(0, 9) != 0);
        v = ($urandom_range(0, 15) != 0);
        a = ($urandom_range(0, 7) == 0);
      end else begin
        r = ($urandom_range(0, 39) != 0);
        v = ($urandom_range(0, 39) != 0);
        a = ($urandom_range(0, 31) == 0);
      end
      l = ($urandom_range(0, 249) == 0);
      step(r, v, a, l, $urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/caliptra_prim_blank_ctrl.md
# caliptra_prim_blank_ctrl

Sequential controller that decides when secret data may leave a blanked path. It generates a glitch-free, registered enable that gates a secret source through an AND primitive toward a consumer. The enable opens only after a request/valid handshake and a fixed arming delay, and it closes on acknowledge, on timeout, or on lock. The block sits between key/secret storage and the consumer datapath, for example a key vault read port feeding a crypto core.

## Interface
- Width, 32, data width of secret path
- ArmCycles, 2, cycles spent in Arm before enable opens; must be >= 1
- MaxOpenCycles, 16, max cycles enable may stay high before forced close; must be >= 1
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_i  in  1  consumer requests secret
- src_valid_i  in  1  source holds valid secret
- lock_i  in  1  force blank; terminal until reset
- ack_i  in  1  consumer has taken data
- data_i  in  Width  secret from source
- en_o  out  1  registered enable, high only in Open
- data_o  out  Width  data_i AND {Width{en_o}} via and2 primitive (combinational from data_i, enable from flop)
- done_o  out  1  one-cycle pulse on normal/timeout close
- timeout_o  out  1  sticky: an Open window expired without ack
- locked_o  out  1  high while in Locked

## Operation
- States: Idle, Arm, Open, Close, Locked. en_o = registered (next_state == Open), so it is never combinationally decoded.
- Idle: req_i & src_valid_i & !lock_i -> Arm, counter loaded to 0.
- Arm: counter increments. When counter == ArmCycles-1 -> Open, counter cleared. If req_i or src_valid_i drops -> Idle. No done_o and no enable in this case.
- Open: counter increments each cycle.
  - ack_i -> Close.
  - Otherwise, req_i or src_valid_i low -> Close.
  - Otherwise, counter == MaxOpenCycles-1 -> Close and set timeout_o.
- Close: done_o = 1 on the first Close cycle only. Stay in Close while req_i is high, with no re-open and no further done. -> Idle when req_i is low.
- Locked: entered from any state when lock_i is sampled high. en_o = 0, done_o = 0, locked_o = 1. Only rst_i exits.
- Priority within a cycle: lock_i > ack_i > req/valid drop > timeout.
- Counter width $clog2(max(ArmCycles,MaxOpenCycles)+1). Counter saturates and never wraps.
- timeout_o is cleared only by reset.

## Timing
- Reset values: state Idle, counter 0. en_o, done_o, timeout_o and locked_o are all 0. data_o is 0 because en_o is 0.
- Reset asserted mid-Open: en_o drops asynchronously with rst_i.
- Request at cycle 0, sampled at edge 1:
  - Arm occupies cycles 1..ArmCycles.
  - en_o is high from cycle ArmCycles+1.
- Open window is at most MaxOpenCycles cycles of en_o high.
- ack_i high in Open cycle k: en_o low in cycle k+1, and done_o is high in cycle k+1.
- ack_i in the final permitted cycle counts as ack: no timeout_o.
- Timeout: en_o low and done_o high in the cycle after the last permitted Open cycle. timeout_o rises in that same cycle.
- lock_i sampled high at an edge: en_o is low and locked_o is high after that edge.
- data_o follows data_i with zero latency while en_o = 1, and is exactly 0 otherwise.

## Test plan
- ArmCycles=2, MaxOpenCycles=16. Raise req_i and src_valid_i at cycle 0, hold data_i=0xA5A5_5A5A, pulse ack_i at cycle 5.
  - en_o is high in cycles 3-5.
  - data_o = 0xA5A5_5A5A in cycles 3-5 and 0 everywhere else.
  - done_o is high in cycle 6 only.
  - timeout_o stays 0.
- Same setup with ack_i never asserted:
  - en_o is high in cycles 3-18.
  - done_o and timeout_o rise in cycle 19.
  - timeout_o stays 1 after req_i drops and a second, acked transaction completes.
- Drop src_valid_i during Arm at cycle 1:
  - en_o never rises.
  - done_o never pulses.
  - State returns to Idle in cycle 2.
- Assert lock_i and ack_i together in Open cycle 4:
  - en_o is 0 and locked_o is 1 from cycle 5.
  - done_o stays 0.
  - A later req_i/src_valid_i is ignored until rst_i.
- Hold req_i high through Close for 10 cycles after an ack:
  - done_o pulses once.
  - en_o stays 0.
  - Idle is re-entered only after req_i goes low.
- Assert rst_i asynchronously mid-Open:
  - en_o and data_o go to 0 immediately.
  - All outputs hold their reset values until rst_i is released.
